// File: rtl/nn_pll_pkg.sv
// rtl/nn_pll_pkg.sv - shared constants and types for the PLL neural-net gain predictor
package nn_pll_pkg;

    // Input averager operand formats
    localparam int NN_N_W       = 4;
    localparam int NN_KP_W      = 8;
    localparam int NN_AVG_W     = 8;
    localparam int NN_AVGN_FRAC = 4;

    // Neural-net weight, bias and accumulator formats (signed fixed point)
    localparam int NN_WGT_W     = 8;
    localparam int NN_WGT_FRAC  = 6;
    localparam int NN_BIAS_W    = 16;
    localparam int NN_BIAS_FRAC = 10;
    localparam int NN_ACC_W     = 24;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } avg_state_t;

endpackage

// File: rtl/nn_window_accum.sv
// rtl/nn_window_accum.sv - windowed sample accumulator with scaled output (NN_AVG_ROUND_EN selects round-half-up)
module nn_window_accum
    import nn_pll_pkg::*;
#(
    parameter int SAMPLE_W = NN_N_W,
    parameter int LOG2_WIN = 4,
    parameter int FRAC     = 0,
    parameter int OUT_W    = NN_AVG_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                add,
    input  logic                last,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [OUT_W-1:0]    result
);

    localparam int SUM_W = SAMPLE_W + LOG2_WIN;
    localparam int SHIFT = LOG2_WIN - FRAC;

`ifdef NN_AVG_ROUND_EN
    localparam int              RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [SUM_W-1:0] ONE = {{(SUM_W-1){1'b0}}, 1'b1};
    localparam logic [SUM_W-1:0] RND = (SHIFT > 0) ? (ONE << RSH) : '0;
`else
    localparam logic [SUM_W-1:0] RND = '0;
`endif

    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] total;
    logic [SUM_W-1:0] rounded;

    // total includes the sample on the inputs so the completing sample is part of the result
    assign total   = sum + SUM_W'(sample);
    assign rounded = total + RND;
    assign result  = OUT_W'(rounded >> SHIFT);

    // running sum: restart on clr or on the window-completing sample, else accumulate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (clr || (add && last)) begin
            sum <= '0;
        end else if (add) begin
            sum <= total;
        end
    end

endmodule

// File: rtl/nn_input_averager.sv
// rtl/nn_input_averager.sv - block averager feeding avgn/avgkp to the neural-net gain predictor
module nn_input_averager
    import nn_pll_pkg::*;
#(
    parameter int LOG2_WIN = 4,
    parameter int N_W      = NN_N_W,
    parameter int KP_W     = NN_KP_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                s_valid,
    input  logic [N_W-1:0]      n_in,
    input  logic [KP_W-1:0]     kp_in,
    output logic [NN_AVG_W-1:0] avgn,
    output logic [NN_AVG_W-1:0] avgkp,
    output logic                avg_valid,
    output logic                avg_primed
);

    avg_state_t          state;
    logic [LOG2_WIN-1:0] cnt;
    logic                accept;
    logic                last;
    logic [NN_AVG_W-1:0] n_scaled;
    logic [NN_AVG_W-1:0] kp_scaled;

    // clr beats a coincident sample, so a cleared sample never reaches the sums
    assign accept = s_valid & ~clr;
    assign last   = (cnt == {LOG2_WIN{1'b1}});

    // EMIT lasts exactly one cycle, so the strobe is a decode of the state register
    assign avg_valid = (state == EMIT);

    nn_window_accum #(
        .SAMPLE_W (N_W),
        .LOG2_WIN (LOG2_WIN),
        .FRAC     (NN_AVGN_FRAC),
        .OUT_W    (NN_AVG_W)
    ) u_accum_n (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .add    (accept),
        .last   (last),
        .sample (n_in),
        .result (n_scaled)
    );

    nn_window_accum #(
        .SAMPLE_W (KP_W),
        .LOG2_WIN (LOG2_WIN),
        .FRAC     (0),
        .OUT_W    (NN_AVG_W)
    ) u_accum_kp (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .add    (accept),
        .last   (last),
        .sample (kp_in),
        .result (kp_scaled)
    );

    // window FSM: count accepted samples, load outputs on the completing sample, EMIT for one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ACCUM;
            cnt        <= '0;
            avgn       <= '0;
            avgkp      <= '0;
            avg_primed <= 1'b0;
        end else begin
            state <= ACCUM;
            if (clr) begin
                cnt <= '0;
            end else if (s_valid) begin
                // the counter wraps to zero on the completing sample
                cnt <= cnt + 1'b1;
                if (last) begin
                    avgn       <= n_scaled;
                    avgkp      <= kp_scaled;
                    avg_primed <= 1'b1;
                    state      <= EMIT;
                end
            end
        end
    end

endmodule

// File: tb/tb_nn_input_averager.sv
// tb/tb_nn_input_averager.sv - scoreboard bench for nn_input_averager
module tb_nn_input_averager;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       s_valid = 1'b0;
    logic [3:0] n_in = '0;
    logic [7:0] kp_in = '0;
    logic [7:0] avgn;
    logic [7:0] avgkp;
    logic       avg_valid;
    logic       avg_primed;

    always #5 clk = ~clk;

    nn_input_averager dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .s_valid    (s_valid),
        .n_in       (n_in),
        .kp_in      (kp_in),
        .avgn       (avgn),
        .avgkp      (avgkp),
        .avg_valid  (avg_valid),
        .avg_primed (avg_primed)
    );

    typedef struct {
        int unsigned cyc;
        logic [7:0]  n;
        logic [7:0]  kp;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          m_cnt = 0;
    int unsigned m_sn = 0;
    int unsigned m_skp = 0;
    logic [7:0]  last_n = '0;
    logic [7:0]  last_kp = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model_kp(input int unsigned s);
`ifdef NN_AVG_ROUND_EN
        return 8'((s + 8) / 16);
`else
        return 8'(s / 16);
`endif
    endfunction

    // window of 16: 4.4 mean of n equals the raw sum
    function automatic logic [7:0] model_n(input int unsigned s);
        return 8'(s);
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_sn  = 0;
        m_skp = 0;
    endtask

    task automatic drive(input logic v, input logic c, input logic [3:0] n, input logic [7:0] kp);
        exp_t e;
        @(posedge clk);
        #1;
        s_valid = v;
        clr     = c;
        n_in    = n;
        kp_in   = kp;
        if (c) begin
            model_reset();
        end else if (v) begin
            m_sn  += n;
            m_skp += kp;
            m_cnt++;
            if (m_cnt == 16) begin
                e.cyc   = cyc + 1;
                e.n     = model_n(m_sn);
                e.kp    = model_kp(m_skp);
                last_n  = e.n;
                last_kp = e.kp;
                q.push_back(e);
                model_reset();
            end
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    // monitor: avg_valid must match the scoreboard every cycle; values checked on each pulse
    always @(negedge clk) begin : mon
        logic ev;
        exp_t e;
        ev = (q.size() > 0) && (q[0].cyc == cyc);
        check_eq("avg_valid", {31'd0, avg_valid}, {31'd0, ev});
        if (ev) begin
            e = q.pop_front();
            check_eq("avgn", {24'd0, avgn}, {24'd0, e.n});
            check_eq("avgkp", {24'd0, avgkp}, {24'd0, e.kp});
            check_eq("avg_primed", {31'd0, avg_primed}, 32'd1);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2;
        check_eq("rst_avgn", {24'd0, avgn}, 32'd0);
        check_eq("rst_avgkp", {24'd0, avgkp}, 32'd0);
        check_eq("rst_valid", {31'd0, avg_valid}, 32'd0);
        check_eq("rst_primed", {31'd0, avg_primed}, 32'd0);
        #5 rst = 1'b0;

        // constant window
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 4'd5, 8'd100);
        idle(2);

        // full scale then zero, back to back
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 4'd15, 8'd255);
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 4'd0, 8'd0);
        idle(2);

        // ascending n, alternating kp (fractional kp mean)
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 4'(i), (i % 2 == 0) ? 8'd3 : 8'd4);
        idle(2);

        // half duty, clr after 8 accepted samples
        for (int i = 0; i < 16; i++) drive(i % 2 == 0, 1'b0, 4'd3, 8'd10);
        drive(1'b1, 1'b1, 4'd9, 8'd99);
        check_eq("clr_hold_avgn", {24'd0, avgn}, {24'd0, last_n});
        check_eq("clr_hold_avgkp", {24'd0, avgkp}, {24'd0, last_kp});
        for (int i = 0; i < 32; i++) drive(i % 2 == 0, 1'b0, 4'd3, 8'd10);
        idle(2);

        // clr on the window-completing sample
        for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 4'd9, 8'd50);
        drive(1'b1, 1'b1, 4'd9, 8'd50);
        idle(2);
        check_eq("clr16_hold_avgn", {24'd0, avgn}, {24'd0, last_n});
        check_eq("clr16_hold_avgkp", {24'd0, avgkp}, {24'd0, last_kp});
        check_eq("clr16_hold_primed", {31'd0, avg_primed}, 32'd1);

        // asynchronous reset mid-window
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 4'd4, 8'd20);
        idle(1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_avgn", {24'd0, avgn}, 32'd0);
        check_eq("arst_avgkp", {24'd0, avgkp}, 32'd0);
        check_eq("arst_primed", {31'd0, avg_primed}, 32'd0);
        check_eq("arst_valid", {31'd0, avg_valid}, 32'd0);
        model_reset();
        q.delete();
        #3 rst = 1'b0;
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 4'd2, 8'd7);
        idle(3);

        check_eq("queue_drain", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
